ysyx_imem_rsp: RTL and testbench

Instruction-memory read responder: the slave end of the IFU fetch bus (ifu_araddr/ifu_arvalid in, ifu_rdata/ifu_rvalid out). It accepts one outstanding word read, waits a fixed or pseudo-random latency, then returns the word with a single-cycle rvalid pulse. It sits between the IFU and the simulation or SoC memory model. A backdoor load port fills the array and exposes per-request status for verification.

---
 rtl/ysyx_imem_rsp.sv | 80 ++++++++
 tb/tb_ysyx_imem_rsp.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ysyx_imem_rsp.sv
// ysyx_imem_rsp: single-outstanding instruction-memory read responder with backdoor load port
module ysyx_imem_rsp #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int LATENCY = 2,
  parameter int RAND_LAT = 0,
  parameter int EXTRA_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic arvalid,
  output logic [DATA_W-1:0] rdata,
  output logic rvalid,
  output logic rerr,
  output logic busy,
  input  logic ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  output logic [31:0] req_cnt,
  output logic [31:0] err_cnt
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = EXTRA_W + 5;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q, off;
  logic [CW-1:0] cnt, cnt_n, lat;
  logic [EXTRA_W-1:0] ext;
  logic [15:0] lfsr;
  logic fault;
  assign ext = RAND_LAT != 0 ? lfsr[EXTRA_W-1:0] : '0;
  assign lat = CW'(LATENCY) + CW'(ext);
  assign off = addr_q - BASE_ADDR;
  assign fault = addr_q[1:0] != 2'b00 || addr_q < BASE_ADDR || (off >> 2) >= ADDR_W'(DEPTH);
  assign rvalid = state == RESP;
  assign rerr = rvalid && fault;
  assign rdata = rvalid && !fault ? mem[off[IW+1:2]] : '0;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    unique case (state)
      IDLE: if (arvalid) begin
        cnt_n = lat - CW'(1);
        state_n = lat == CW'(1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - CW'(1);
        state_n = cnt == CW'(1) ? RESP : WAIT;
      end
      RESP: state_n = HOLD;
      HOLD: state_n = arvalid ? HOLD : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      req_cnt <= '0;
      err_cnt <= '0;
      lfsr <= 16'hACE1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state == IDLE && arvalid) begin
        addr_q <= araddr;
        req_cnt <= req_cnt + 32'd1;
      end
      if (rerr) err_cnt <= err_cnt + 32'd1;
    end
  end
  // Backdoor port is deliberately outside reset so preloads survive it
  always_ff @(posedge clk) if (ld_en) mem[ld_idx] <= ld_data;
endmodule

// File: tb/tb_ysyx_imem_rsp.sv
// tb_ysyx_imem_rsp: directed checks of the imem responder at fixed, unit and random latency
module tb_ysyx_imem_rsp;
  logic clk = 0;
  logic rst, ld_en;
  logic [9:0] ld_idx;
  logic [31:0] ld_data;
  logic [31:0] a0, a1, a2, d0, d1, d2, rc0, rc1, rc2, ec0, ec1, ec2;
  logic v0, v1, v2, r0, r1, r2, e0, e1, e2, b0, b1, b2;
  int checks = 0, failures = 0;
  int lat [2][200];
  logic [31:0] bad_addr [3] = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_1000};

  always #5 clk = ~clk;

  ysyx_imem_rsp #(.LATENCY(2)) u0 (.clk(clk), .rst(rst), .araddr(a0), .arvalid(v0), .rdata(d0),
    .rvalid(r0), .rerr(e0), .busy(b0), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .req_cnt(rc0), .err_cnt(ec0));
  ysyx_imem_rsp #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .araddr(a1), .arvalid(v1), .rdata(d1),
    .rvalid(r1), .rerr(e1), .busy(b1), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .req_cnt(rc1), .err_cnt(ec1));
  ysyx_imem_rsp #(.LATENCY(2), .RAND_LAT(1), .EXTRA_W(2)) u2 (.clk(clk), .rst(rst), .araddr(a2),
    .arvalid(v2), .rdata(d2), .rvalid(r2), .rerr(e2), .busy(b2), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_data(ld_data), .req_cnt(rc2), .err_cnt(ec2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1;
    ld_idx = idx[9:0];
    ld_data = d;
    tick();
    ld_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, diff;
    logic [3:0] seen;
    rst = 1; ld_en = 0; ld_idx = '0; ld_data = '0;
    a0 = '0; a1 = '0; a2 = 32'h8000_0000; v0 = 0; v1 = 0; v2 = 0;
    tick();
    load(0, 32'h0000_0413);
    load(1, 32'h00A0_0093);
    load(2, 32'hDEAD_BEEF);
    rst = 0; v0 = 1; a0 = 32'h8000_0000;
    chk("rst_rvalid", r0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_rdata", d0, 0);
    chk("rst_req_cnt", rc0, 0);
    chk("rst_err_cnt", ec0, 0);
    tick();
    chk("wait_rvalid", r0, 0);
    chk("wait_busy", b0, 1);
    tick();
    chk("rsp0_rvalid", r0, 1);
    chk("rsp0_rdata", d0, 32'h0000_0413);
    chk("rsp0_rerr", e0, 0);
    chk("rsp0_req_cnt", rc0, 1);
    n = 0;
    repeat (4) begin tick(); n += int'(r0); end
    chk("held_no_second_rvalid", n, 0);
    chk("held_busy", b0, 1);
    chk("held_rdata_zero", d0, 0);
    v0 = 0;
    tick();
    chk("rearm_idle", b0, 0);
    v0 = 1; a0 = 32'h8000_0004;
    tick(); tick();
    chk("rsp1_rvalid", r0, 1);
    chk("rsp1_rdata", d0, 32'h00A0_0093);
    chk("rsp1_req_cnt", rc0, 2);
    v0 = 0; tick(); tick();
    for (int i = 0; i < 3; i++) begin
      v0 = 1; a0 = bad_addr[i];
      tick(); tick();
      chk("fault_rvalid", r0, 1);
      chk("fault_rerr", e0, 1);
      chk("fault_rdata", d0, 0);
      v0 = 0; tick(); tick();
    end
    chk("fault_err_cnt", ec0, 3);
    chk("fault_req_cnt", rc0, 5);
    v0 = 1; a0 = 32'h8000_0008;
    tick();
    ld_en = 1; ld_idx = 10'd2; ld_data = 32'hCAFE_F00D;
    tick();
    ld_en = 0;
    chk("ld_in_wait_rdata", d0, 32'hCAFE_F00D);
    v0 = 0; tick(); tick();
    v1 = 1; a1 = 32'h8000_0000;
    chk("lat1_accept_rvalid", r1, 0);
    tick();
    a1 = 32'h8000_0008;
    chk("lat1_rvalid", r1, 1);
    chk("lat1_latched_rdata", d1, 32'h0000_0413);
    v1 = 0; tick();
    chk("lat1_pulse_end", r1, 0);
    tick();
    for (int p = 0; p < 2; p++) begin
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 200; i++) begin
        v2 = 1;
        tick();
        n = 1;
        while (!r2 && n < 20) begin tick(); n++; end
        lat[p][i] = n;
        v2 = 0; tick(); tick();
      end
      chk("rand_req_cnt", rc2, 200);
    end
    bad = 0; diff = 0; seen = '0;
    for (int i = 0; i < 200; i++) begin
      if (lat[0][i] < 2 || lat[0][i] > 5) bad++;
      else seen[lat[0][i] - 2] = 1'b1;
      if (lat[0][i] != lat[1][i]) diff++;
    end
    chk("rand_out_of_range", bad, 0);
    chk("rand_all_values_seen", {28'd0, seen}, 32'hF);
    chk("rand_repeat_diffs", diff, 0);
    v0 = 1; a0 = 32'h8000_0000;
    tick();
    chk("abort_busy_before", b0, 1);
    rst = 1;
    tick();
    rst = 0; v0 = 0;
    chk("abort_rvalid", r0, 0);
    chk("abort_busy", b0, 0);
    chk("abort_req_cnt", rc0, 0);
    chk("abort_err_cnt", ec0, 0);
    n = 0;
    repeat (3) begin tick(); n += int'(r0); end
    chk("abort_no_late_rvalid", n, 0);
    v0 = 1;
    tick(); tick();
    chk("post_rst_rvalid", r0, 1);
    chk("post_rst_mem0", d0, 32'h0000_0413);
    v0 = 0; tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
